// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx -- PS/2 device-to-host frame receiver.
//
// Receives one 11-bit PS/2 frame (start, 8 data bits LSB first, parity, stop)
// clocked by the device on falling edges of ps2c. Both PS/2 lines are
// synchronised into clk, and ps2c is debounced before edge detection.
//
// Optional feature macro: PS2_FRAME_RX_PARITY_CHK_EN
//   defined   -> odd parity over data+parity is checked; a failure pulses
//                parity_err instead of rx_done_tick.
//   undefined -> parity bit is ignored and parity_err is tied low.
//
// Parameters
//   FILTER_LEN   ps2c debounce depth in clk cycles (must be >= 2)
//   TIMEOUT_CYC  max clk cycles allowed between ps2c falling edges in a frame
//
// Ports
//   clk           system clock (single domain)
//   reset         synchronous, active-high reset
//   rx_en         permits the start of a new frame
//   ps2d          PS/2 data line (asynchronous)
//   ps2c          PS/2 clock line (asynchronous)
//   rx_done_tick  one-cycle pulse: valid byte on dout
//   dout          last valid received byte
//   frame_err     one-cycle pulse: bad start/stop bit or inter-edge timeout
//   parity_err    one-cycle pulse: odd-parity failure

module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Odd parity: XOR over the 8 data bits and the parity bit must be 1.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

    state_t state, state_next;

    // ---- synchroniser stage ------------------------------------------------
    logic ps2c_p0, ps2c_p1;
    logic ps2d_p0, ps2d_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
            ps2d_p0 <= 1'b1;
            ps2d_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= ps2c;
            ps2c_p1 <= ps2c_p0;
            ps2d_p0 <= ps2d;
            ps2d_p1 <= ps2d_p0;
        end
    end

    // ---- debounce filter and falling-edge detect stage ---------------------
    logic [FILTER_LEN-1:0] filt_reg, filt_next;
    logic                  f_ps2c, f_ps2c_next, f_ps2c_prev;
    logic                  fall_edge;

    always_comb begin
        filt_next = {filt_reg[FILTER_LEN-2:0], ps2c_p1};
        // Hysteresis: only a full run of identical samples moves the output.
        if (&filt_next)
            f_ps2c_next = 1'b1;
        else if (~|filt_next)
            f_ps2c_next = 1'b0;
        else
            f_ps2c_next = f_ps2c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_reg    <= '1;
            f_ps2c      <= 1'b1;
            f_ps2c_prev <= 1'b1;
        end else begin
            filt_reg    <= filt_next;
            f_ps2c      <= f_ps2c_next;
            f_ps2c_prev <= f_ps2c;
        end
    end

    assign fall_edge = f_ps2c_prev & ~f_ps2c;

    // ---- frame assembly FSM ------------------------------------------------
    logic [10:0]   b_reg, b_next;
    logic [3:0]    n_reg, n_next;
    logic [TW-1:0] t_reg, t_next;
    logic          last_edge;
    logic          timeout;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b_reg <= '0;
            n_reg <= '0;
            t_reg <= '0;
        end else begin
            b_reg <= b_next;
            n_reg <= n_next;
            t_reg <= t_next;
        end
    end

    always_comb begin
        state_next = state;
        b_next     = b_reg;
        n_next     = n_reg;
        t_next     = t_reg;
        last_edge  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                t_next = '0;
                if (fall_edge && rx_en) begin
                    b_next     = {ps2d_p1, b_reg[10:1]};
                    n_next     = 4'd9;
                    state_next = DPS;
                end
            end
            DPS: begin
                // rx_en is deliberately not consulted: a started frame runs
                // to completion or timeout.
                if (fall_edge) begin
                    b_next = {ps2d_p1, b_reg[10:1]};
                    t_next = '0;
                    if (n_reg == 4'd0) begin
                        last_edge  = 1'b1;
                        state_next = LOAD;
                    end else begin
                        n_next = n_reg - 4'd1;
                    end
                end else if (t_reg == TMO_MAX) begin
                    timeout    = 1'b1;
                    t_next     = '0;
                    state_next = IDLE;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            LOAD: begin
                t_next     = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- output stage ------------------------------------------------------
    // The frame is judged on the edge that completes it, using the shifted
    // value, so the registered pulses are visible during the LOAD cycle,
    // one cycle after the 11th edge.
    logic       frame_ok, parity_ok;
    logic       tick_next, ferr_next;
    logic [7:0] dout_next;

    assign frame_ok = ~b_next[0] & b_next[10];
`ifdef PS2_FRAME_RX_PARITY_CHK_EN
    assign parity_ok = odd_parity_ok(b_next[9:1]);
    logic perr_next;
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        tick_next = 1'b0;
        ferr_next = 1'b0;
        dout_next = dout;
`ifdef PS2_FRAME_RX_PARITY_CHK_EN
        perr_next = 1'b0;
`endif
        if (timeout) begin
            ferr_next = 1'b1;
        end else if (last_edge) begin
            if (!frame_ok) begin
                ferr_next = 1'b1;
            end else if (!parity_ok) begin
`ifdef PS2_FRAME_RX_PARITY_CHK_EN
                perr_next = 1'b1;
`endif
            end else begin
                tick_next = 1'b1;
                dout_next = b_next[8:1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            dout         <= 8'h00;
        end else begin
            rx_done_tick <= tick_next;
            frame_err    <= ferr_next;
            dout         <= dout_next;
        end
    end

`ifdef PS2_FRAME_RX_PARITY_CHK_EN
    always_ff @(posedge clk) begin
        if (reset)
            parity_err <= 1'b0;
        else
            parity_err <= perr_next;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed scenarios plus randomized
// frames, judged against a frame-level reference model.
module tb_ps2_frame_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 20;  // PS/2 clock half period in clk cycles
    // Pin-to-tick latency: 2 sync flops + FILTER_LEN filter samples bring the
    // detected edge, the tick follows one cycle later.
    localparam int TICK_LAT    = FILTER_LEN + 3;
`ifdef PS2_FRAME_RX_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       parity_err;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_en       (rx_en),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: counts high cycles of each pulse (a stuck pulse shows
    // up as a count above one).
    int n_tick = 0, n_ferr = 0, n_perr = 0;
    int tick_cyc = -1;
    always @(negedge clk) begin
        if (rx_done_tick) begin
            n_tick++;
            tick_cyc = cyc;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
    end

    int n_cmp = 0, n_bad = 0;
    logic [7:0] exp_dout = 8'h00;
    int last_drive = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first nedges bits of a frame, LSB first. rx_en drops to 0
    // right after edge index drop_at (negative: never).
    task automatic send_bits(input logic [10:0] bits, input int nedges, input int drop_at);
        for (int i = 0; i < nedges; i++) begin
            ps2d = bits[i];
            wait_cyc(HALF);
            ps2c = 1'b0;
            last_drive = cyc;
            if (i == drop_at) rx_en = 1'b0;
            wait_cyc(HALF);
            ps2c = 1'b1;
        end
    endtask

    // Send one complete frame and compare the outcome with the model.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic par,
                             input logic start, input logic stop, input logic en,
                             input int drop_at);
        int t0, f0, p0;
        int e_tick, e_ferr, e_perr;
        logic [10:0] bits;
        bits = {stop, par, data, start};
        t0 = n_tick; f0 = n_ferr; p0 = n_perr;
        rx_en = en;
        send_bits(bits, 11, drop_at);
        wait_cyc(30);
        rx_en = 1'b1;
        // Reference model: the frame-level decision rules.
        e_tick = 0; e_ferr = 0; e_perr = 0;
        if (en) begin
            if (start != 1'b0 || stop != 1'b1)
                e_ferr = 1;
            else if (PAR_EN && ((^{data, par}) != 1'b1))
                e_perr = 1;
            else begin
                e_tick   = 1;
                exp_dout = data;
            end
        end
        chk({tag, ".tick"}, n_tick - t0, e_tick);
        chk({tag, ".ferr"}, n_ferr - f0, e_ferr);
        chk({tag, ".perr"}, n_perr - p0, e_perr);
        chk({tag, ".dout"}, dout, exp_dout);
        if (e_tick == 1)
            chk({tag, ".lat"}, tick_cyc - last_drive, TICK_LAT);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    initial begin
        int t0, f0, p0;
        logic [7:0] d;
        logic       p, s, e, en;
        int         drop;

        // Reset state
        wait_cyc(5);
        chk("rst.tick", rx_done_tick, 0);
        chk("rst.ferr", frame_err, 0);
        chk("rst.perr", parity_err, 0);
        chk("rst.dout", dout, 8'h00);
        reset = 1'b0;
        wait_cyc(5);

        // Valid 0x1C, parity 0
        run_frame("f1c", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        // 0x1C with parity 1: parity error only when checking is built in
        run_frame("f1c_badpar", 8'h1C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        // Establish a different dout, then a stop-bit error on 0x2A
        run_frame("f55", 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_frame("f2a_stop", 8'h2A, odd_par(8'h2A), 1'b0, 1'b0, 1'b1, -1);
        run_frame("bad_start", 8'h33, odd_par(8'h33), 1'b1, 1'b1, 1'b1, -1);

        // Timeout after 5 edges, then 0xF0 parity 1
        t0 = n_tick; f0 = n_ferr; p0 = n_perr;
        send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 5, -1);
        wait_cyc(TIMEOUT_CYC + 100);
        chk("tmo.ferr", n_ferr - f0, 1);
        chk("tmo.tick", n_tick - t0, 0);
        chk("tmo.perr", n_perr - p0, 0);
        chk("tmo.dout", dout, exp_dout);
        run_frame("ff0", 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, -1);

        // Short ps2c glitch in IDLE
        t0 = n_tick; f0 = n_ferr; p0 = n_perr;
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(60);
        chk("glitch.cnt", (n_tick - t0) + (n_ferr - f0) + (n_perr - p0), 0);
        run_frame("after_glitch", 8'hA5, odd_par(8'hA5), 1'b0, 1'b1, 1'b1, -1);

        // Frame with rx_en low is ignored; receiver stays ready
        run_frame("en_off", 8'h3C, odd_par(8'h3C), 1'b0, 1'b1, 1'b0, -1);
        run_frame("after_en_off", 8'h7E, odd_par(8'h7E), 1'b0, 1'b1, 1'b1, -1);

        // rx_en dropped mid-frame does not abort it
        run_frame("en_drop", 8'h81, odd_par(8'h81), 1'b0, 1'b1, 1'b1, 3);

        // Reset after 6 edges of 0x1C
        t0 = n_tick; f0 = n_ferr; p0 = n_perr;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, -1);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        exp_dout = 8'h00;
        wait_cyc(TIMEOUT_CYC + 50);
        chk("rstmid.cnt", (n_tick - t0) + (n_ferr - f0) + (n_perr - p0), 0);
        chk("rstmid.dout", dout, 8'h00);
        run_frame("after_rst", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        // Randomized frames
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            p    = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
            s    = ($urandom_range(0, 7) == 0);
            e    = ($urandom_range(0, 7) != 0);
            en   = ($urandom_range(0, 7) != 0);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            run_frame($sformatf("rnd%0d", k), d, p, s, e, en, en ? drop : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
